// File: rtl/load_buffer_writer.sv
// load_buffer_writer: executes one load instruction. On ap_start it latches the
// instruction, issues a single DRAM read request, then writes the returned stream
// beats into the selected buffer channel at consecutive (wrapping) word addresses,
// and finishes with an ap_done pulse.
//
// Optional feature: define LOAD_ERR_CHECK_EN to enable the sticky err flag
// (tlast misplaced/missing, buffer id out of range). Undefined: err is tied 0.
//
// Ports:
//   kernel_clk, kernel_rst         clock, async active-high reset
//   ap_start, ctrl_addr_offset,    instruction strobe, DRAM base byte address,
//   ctrl_instruction               instruction word
//   ap_done, busy                  completion pulse, busy flag
//   dram_xfer_start_addr,          read request address/size, held while busy
//   dram_xfer_size_in_bytes,
//   read_start                     one-cycle read request pulse
//   data_tvalid/tlast/tdata/tready input stream
//   buf_wr_valid/addr/data         one-hot buffer write port
//   err                            sticky error flag
module load_buffer_writer #(
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned XFER_W  = 32,
    parameter int unsigned NUM_BUF = 5,
    parameter int unsigned BUF_AW  = 11
) (
    input  logic                kernel_clk,
    input  logic                kernel_rst,
    input  logic                ap_start,
    input  logic [ADDR_W-1:0]   ctrl_addr_offset,
    input  logic [95:0]         ctrl_instruction,
    output logic                ap_done,
    output logic                busy,
    output logic [ADDR_W-1:0]   dram_xfer_start_addr,
    output logic [XFER_W-1:0]   dram_xfer_size_in_bytes,
    output logic                read_start,
    input  logic                data_tvalid,
    input  logic                data_tlast,
    input  logic [DATA_W-1:0]   data_tdata,
    output logic                data_tready,
    output logic [NUM_BUF-1:0]  buf_wr_valid,
    output logic [BUF_AW-1:0]   buf_wr_addr,
    output logic [DATA_W-1:0]   buf_wr_data,
    output logic                err
);

    localparam int unsigned LINE = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, STREAM, DONE} state_t;

    state_t               state, state_next;
    logic [3:0]           buf_id, id_next;
    logic [15:0]          buf_start, start_next;
    logic [15:0]          line_count, count_next;
    logic [15:0]          received, recv_next;
    logic                 busy_next, ap_done_next, read_start_next, tready_next;
    logic [ADDR_W-1:0]    addr_next;
    logic [XFER_W-1:0]    size_next;
    logic [NUM_BUF-1:0]   wr_valid_next;
    logic [BUF_AW-1:0]    wr_addr_next;
    logic [DATA_W-1:0]    wr_data_next;

    logic beat_accept;
    logic last_beat;
    logic id_bad;

    // Reserved instruction bits carry no function.
    logic unused_bits;
    assign unused_bits = ^{ctrl_instruction[95:64], ctrl_instruction[15:4], data_tlast};

    assign beat_accept = data_tvalid && data_tready;
    assign last_beat   = (received + 16'd1) == line_count;
    assign id_bad      = 32'(buf_id) >= NUM_BUF;

`ifdef LOAD_ERR_CHECK_EN
    logic err_q, err_next;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_next      = state;
        busy_next       = busy;
        ap_done_next    = 1'b0;
        read_start_next = 1'b0;
        tready_next     = data_tready;
        wr_valid_next   = '0;
        wr_addr_next    = buf_wr_addr;
        wr_data_next    = buf_wr_data;
        id_next         = buf_id;
        start_next      = buf_start;
        count_next      = line_count;
        recv_next       = received;
        addr_next       = dram_xfer_start_addr;
        size_next       = dram_xfer_size_in_bytes;
`ifdef LOAD_ERR_CHECK_EN
        err_next        = err_q;
        if (state != IDLE && id_bad) begin
            err_next = 1'b1;
        end
`endif
        case (state)
            IDLE: begin
                // ap_start coinciding with the ap_done pulse belongs to the finished job.
                if (ap_start && !ap_done) begin
                    id_next    = ctrl_instruction[3:0];
                    start_next = ctrl_instruction[31:16];
                    count_next = ctrl_instruction[63:48];
                    recv_next  = 16'd0;
                    addr_next  = ctrl_addr_offset
                               + ADDR_W'(ctrl_instruction[47:32]) * ADDR_W'(LINE);
                    size_next  = XFER_W'(64'(ctrl_instruction[63:48]) * 64'(LINE));
                    busy_next  = 1'b1;
`ifdef LOAD_ERR_CHECK_EN
                    err_next   = 1'b0;
`endif
                    state_next = (ctrl_instruction[63:48] == 16'd0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                read_start_next = 1'b1;
                tready_next     = 1'b1;
                state_next      = STREAM;
            end
            STREAM: begin
                if (beat_accept) begin
                    wr_valid_next = id_bad ? '0 : (NUM_BUF'(1) << buf_id);
                    wr_addr_next  = BUF_AW'(buf_start + received);
                    wr_data_next  = data_tdata;
                    recv_next     = received + 16'd1;
`ifdef LOAD_ERR_CHECK_EN
                    if (data_tlast != last_beat) begin
                        err_next = 1'b1;
                    end
`endif
                    if (last_beat) begin
                        tready_next = 1'b0;
                        state_next  = DONE;
                    end
                end
            end
            DONE: begin
                ap_done_next = 1'b1;
                busy_next    = 1'b0;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            state                   <= IDLE;
            busy                    <= 1'b0;
            ap_done                 <= 1'b0;
            read_start              <= 1'b0;
            data_tready             <= 1'b0;
            buf_wr_valid            <= '0;
            buf_wr_addr             <= '0;
            buf_wr_data             <= '0;
            buf_id                  <= '0;
            buf_start               <= '0;
            line_count              <= '0;
            received                <= '0;
            dram_xfer_start_addr    <= '0;
            dram_xfer_size_in_bytes <= '0;
        end else begin
            state                   <= state_next;
            busy                    <= busy_next;
            ap_done                 <= ap_done_next;
            read_start              <= read_start_next;
            data_tready             <= tready_next;
            buf_wr_valid            <= wr_valid_next;
            buf_wr_addr             <= wr_addr_next;
            buf_wr_data             <= wr_data_next;
            buf_id                  <= id_next;
            buf_start               <= start_next;
            line_count              <= count_next;
            received                <= recv_next;
            dram_xfer_start_addr    <= addr_next;
            dram_xfer_size_in_bytes <= size_next;
        end
    end

`ifdef LOAD_ERR_CHECK_EN
    // Sticky error register.
    always_ff @(posedge kernel_clk or posedge kernel_rst) begin
        if (kernel_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_next;
        end
    end
`endif

endmodule

// File: tb/tb_load_buffer_writer.sv
module tb_load_buffer_writer;

    localparam int unsigned DATA_W  = 512;
    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned XFER_W  = 32;
    localparam int unsigned NUM_BUF = 5;
    localparam int unsigned BUF_AW  = 11;
    localparam int LIMIT = 3000;

    logic                kernel_clk = 1'b0;
    logic                kernel_rst = 1'b1;
    logic                ap_start = 1'b0;
    logic [ADDR_W-1:0]   ctrl_addr_offset = '0;
    logic [95:0]         ctrl_instruction = '0;
    logic                ap_done, busy, read_start, data_tready, err;
    logic [ADDR_W-1:0]   dram_xfer_start_addr;
    logic [XFER_W-1:0]   dram_xfer_size_in_bytes;
    logic                data_tvalid = 1'b0;
    logic                data_tlast = 1'b0;
    logic [DATA_W-1:0]   data_tdata = '0;
    logic [NUM_BUF-1:0]  buf_wr_valid;
    logic [BUF_AW-1:0]   buf_wr_addr;
    logic [DATA_W-1:0]   buf_wr_data;

    load_buffer_writer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .XFER_W(XFER_W),
        .NUM_BUF(NUM_BUF), .BUF_AW(BUF_AW)
    ) dut (
        .kernel_clk(kernel_clk), .kernel_rst(kernel_rst),
        .ap_start(ap_start), .ctrl_addr_offset(ctrl_addr_offset),
        .ctrl_instruction(ctrl_instruction),
        .ap_done(ap_done), .busy(busy),
        .dram_xfer_start_addr(dram_xfer_start_addr),
        .dram_xfer_size_in_bytes(dram_xfer_size_in_bytes),
        .read_start(read_start),
        .data_tvalid(data_tvalid), .data_tlast(data_tlast), .data_tdata(data_tdata),
        .data_tready(data_tready),
        .buf_wr_valid(buf_wr_valid), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .err(err)
    );

    always #5 kernel_clk = ~kernel_clk;

    typedef struct {
        logic [3:0]  id;
        logic [15:0] start;
        logic [15:0] offset;
        logic [15:0] count;
        logic [63:0] base;
        int          extra;     // beats offered beyond count
        int          pattern;   // 0 always valid, 1 every other cycle, 2 random
        int          tlast_at;  // beat index carrying tlast
        bit          spam;      // hold ap_start high with garbage while busy
        logic [63:0] exp_addr;
        logic [31:0] exp_size;
    } vec_t;

    vec_t vecs[8];
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] id, input logic [15:0] start,
                                input logic [15:0] offset, input logic [15:0] count,
                                input logic [63:0] base, input int extra, input int pattern,
                                input bit spam, input logic [63:0] ea, input logic [31:0] es);
        vec_t v;
        v.id = id; v.start = start; v.offset = offset; v.count = count; v.base = base;
        v.extra = extra; v.pattern = pattern; v.spam = spam;
        v.tlast_at = int'(count) - 1;
        v.exp_addr = ea; v.exp_size = es;
        return v;
    endfunction

    // One instruction: offer a stream and check everything the DUT does against
    // the rule "the k-th accepted beat lands at (start+k) mod 2^BUF_AW on channel id".
    task automatic run_txn(input vec_t v, input int abort_after);
        logic [511:0] beats[$];
        logic [511:0] b;
        logic [NUM_BUF-1:0] oh;
        int supply, bi, wn, rs, done_neg;
        bit lr, aborted, exp_err;
        supply = int'(v.count) + v.extra;
        for (int i = 0; i < supply; i++) begin
            for (int j = 0; j < 16; j++) b[j*32 +: 32] = $urandom;
            beats.push_back(b);
        end
        oh = (32'(v.id) < NUM_BUF) ? (NUM_BUF'(1) << v.id) : '0;
        bi = 0; wn = 0; rs = 0; done_neg = -1; lr = 1'b0; aborted = 1'b0;

        @(negedge kernel_clk);
        ctrl_addr_offset = v.base;
        ctrl_instruction = {32'h0, v.count, v.offset, v.start, 12'h0, v.id};
        ap_start = 1'b1;
        for (int n = 1; n <= LIMIT; n++) begin
            @(negedge kernel_clk);
            if (v.spam) begin
                ctrl_instruction = {$urandom, $urandom, $urandom};
                ctrl_addr_offset = {$urandom, $urandom};
            end else begin
                ap_start = 1'b0;
            end
            if (n == 1) chk("busy_after_start", busy, 1);
            if (data_tvalid && lr) bi++;
            lr = data_tready;
            if (read_start) begin
                rs++;
                chk("req_addr", dram_xfer_start_addr, v.exp_addr);
                chk("req_size", dram_xfer_size_in_bytes, v.exp_size);
            end
            if (|buf_wr_valid) begin
                chk("wr_valid", buf_wr_valid, oh);
                chk("wr_addr", buf_wr_addr, (int'(v.start) + wn) % (1 << BUF_AW));
                if (wn < supply) chk("wr_data", buf_wr_data, beats[wn]);
                wn++;
            end
            if (abort_after > 0 && wn == abort_after) begin
                kernel_rst = 1'b1;
                #1;
                chk("rst_outputs", {busy, ap_done, read_start, data_tready, |buf_wr_valid,
                    |buf_wr_addr, |buf_wr_data, err, |dram_xfer_start_addr,
                    |dram_xfer_size_in_bytes}, 0);
                data_tvalid = 1'b0;
                @(negedge kernel_clk);
                kernel_rst = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge kernel_clk);
                    chk("no_done_after_rst", {ap_done, busy, read_start, |buf_wr_valid}, 0);
                end
                aborted = 1'b1;
                break;
            end
            if (ap_done) begin
                done_neg = n;
                break;
            end
            if (bi < supply && (v.pattern == 0 || (v.pattern == 1 && n % 2 == 0) ||
                                (v.pattern == 2 && $urandom_range(0, 1) == 1))) begin
                data_tvalid = 1'b1;
                data_tdata  = beats[bi];
                data_tlast  = (bi == v.tlast_at);
            end else begin
                data_tvalid = 1'b0;
                data_tlast  = 1'b0;
            end
        end
        if (aborted) return;
        if (done_neg < 0) begin
            total++; bad++;
            $display("FAIL timeout: no ap_done within %0d cycles", LIMIT);
        end
        chk("tready_low_at_done", data_tready, 0);
        @(negedge kernel_clk);
        ap_start = 1'b0;
        data_tvalid = 1'b0;
        data_tlast = 1'b0;
        chk("done_single_pulse", ap_done, 0);
        chk("idle_after_done", busy, 0);
        chk("read_start_count", rs, (v.count != 0) ? 1 : 0);
        chk("write_count", wn, (32'(v.id) < NUM_BUF) ? int'(v.count) : 0);
        chk("beats_consumed", bi, int'(v.count));
        chk("req_addr_held", dram_xfer_start_addr, v.exp_addr);
        if (v.count == 0) chk("zero_count_latency", done_neg, 2);
`ifdef LOAD_ERR_CHECK_EN
        exp_err = (32'(v.id) >= NUM_BUF) || (v.count != 0 && v.tlast_at != int'(v.count) - 1);
`else
        exp_err = 1'b0;
`endif
        chk("err", err, exp_err);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = mk(4'd0, 16'd0,    16'd2,      16'd128, 64'h0,    0, 0, 1'b0, 64'd128,   32'd8192);
        vecs[1] = mk(4'd2, 16'd2040, 16'd0,      16'd16,  64'h0,    0, 1, 1'b0, 64'd0,     32'd1024);
        vecs[2] = mk(4'd1, 16'd5,    16'd5,      16'd0,   64'h0,    0, 0, 1'b0, 64'd320,   32'd0);
        vecs[3] = mk(4'd3, 16'd100,  16'd3,      16'd16,  64'h1000, 4, 0, 1'b0, 64'h10C0,  32'd1024);
        vecs[4] = mk(4'd4, 16'd2047, 16'hFFFF,   16'd1,   64'h10,   0, 0, 1'b1, 64'h3FFFD0, 32'd64);
        vecs[5] = mk(4'd2, 16'd0,    16'd1,      16'd16,  64'h0,    0, 0, 1'b0, 64'd64,    32'd1024);
        vecs[5].tlast_at = 9;
        vecs[6] = mk(4'd9, 16'd0,    16'd1,      16'd4,   64'h40,   0, 0, 1'b0, 64'h80,    32'd256);
        vecs[7] = mk(4'd0, 16'd2000, 16'd7,      16'd64,  64'hFFFF_FFFF_FFFF_FFC0, 2, 2, 1'b1,
                     64'h180, 32'd4096);

        repeat (3) @(negedge kernel_clk);
        chk("reset_outputs", {busy, ap_done, read_start, data_tready, |buf_wr_valid,
            |buf_wr_addr, |buf_wr_data, err, |dram_xfer_start_addr,
            |dram_xfer_size_in_bytes}, 0);
        kernel_rst = 1'b0;
        @(negedge kernel_clk);
        chk("idle_after_reset", busy, 0);

        for (int i = 0; i < 8; i++) run_txn(vecs[i], 0);

        // Reset during a 64-beat transfer, then the same instruction again.
        rv = mk(4'd1, 16'd10, 16'd0, 16'd64, 64'h0, 0, 0, 1'b0, 64'd0, 32'd4096);
        run_txn(rv, 5);
        run_txn(rv, 0);

        for (int i = 0; i < 12; i++) begin
            rv.id       = 4'($urandom_range(0, 6));
            rv.start    = 16'($urandom);
            rv.offset   = 16'($urandom);
            rv.count    = 16'($urandom_range(0, 40));
            rv.base     = {$urandom, $urandom};
            rv.extra    = $urandom_range(0, 4);
            rv.pattern  = $urandom_range(0, 2);
            rv.spam     = 1'($urandom_range(0, 1));
            rv.tlast_at = int'(rv.count) - 1;
            rv.exp_addr = rv.base + 64'(rv.offset) * 64'(DATA_W / 8);
            rv.exp_size = 32'(rv.count) * 32'(DATA_W / 8);
            run_txn(rv, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_buffer_writer.md
LOAD_BUFFER_WRITER -- requirements
Module: load_buffer_writer

Interface
REQ-001 Parameter DATA_W, default 512, stream/buffer word width in bits (multiple of 8).
REQ-002 Parameter ADDR_W, default 64, DRAM byte-address width.
REQ-003 Parameter XFER_W, default 32, transfer-size width in bytes.
REQ-004 Parameter NUM_BUF, default 5, number of buffer write channels (1..16).
REQ-005 Parameter BUF_AW, default 11, buffer word-address width.
REQ-006 kernel_clk  in  1  clock; all logic rising-edge.
REQ-007 kernel_rst  in  1  reset, asynchronous, active-high.
REQ-008 ap_start  in  1  one-cycle instruction strobe.
REQ-009 ctrl_addr_offset  in  ADDR_W  DRAM base byte address.
REQ-010 ctrl_instruction  in  96  instruction word: [3:0] dst buffer id, [15:4] reserved, [31:16] buffer start word, [47:32] DRAM line offset, [63:48] line count, [95:64] reserved.
REQ-011 ap_done  out  1  one-cycle completion pulse.
REQ-012 busy  out  1  high from accepted ap_start until ap_done.
REQ-013 dram_xfer_start_addr / dram_xfer_size_in_bytes  out  ADDR_W / XFER_W  read request, held stable while busy.
REQ-014 read_start  out  1  one-cycle read-request pulse.
REQ-015 data_tvalid, data_tlast  in  1  stream beat valid and last-beat flag.
REQ-016 data_tdata  in  DATA_W  stream data.
REQ-017 data_tready  out  1  stream accept.
REQ-018 buf_wr_valid  out  NUM_BUF  one-hot write enable per channel.
REQ-019 buf_wr_addr / buf_wr_data  out  BUF_AW / DATA_W  shared write address and data.
REQ-020 err  out  1  sticky error flag (see Configuration).

Function
REQ-021 LINE = DATA_W/8 bytes; start addr SHALL be ctrl_addr_offset + offset*LINE; size SHALL be count*LINE, truncated to XFER_W.
REQ-022 FSM states IDLE, ISSUE, STREAM, DONE; reset state IDLE.
REQ-023 IDLE: ap_start latches instruction and ctrl_addr_offset, sets busy -> ISSUE next cycle; ap_start while busy SHALL be ignored.
REQ-024 Line count 0: IDLE -> DONE directly; no read_start, no buffer writes.
REQ-025 ISSUE: read_start pulses exactly one cycle, address/size valid same cycle -> STREAM.
REQ-026 STREAM: data_tready high while received < count; beat accepted when tvalid&&tready.
REQ-027 Accepted beat SHALL drive buf_wr_valid[id], buf_wr_addr=start+received (mod 2^BUF_AW, wraps), buf_wr_data=tdata, registered, one cycle after acceptance.
REQ-028 After the count-th beat: tready low same cycle as transition -> DONE; extra beats not accepted.
REQ-029 DONE: ap_done pulses one cycle, busy drops same cycle -> IDLE; ap_start on that cycle ignored.
REQ-030 tvalid low in STREAM: no write, counter holds, no timeout.
REQ-031 Buffer id >= NUM_BUF: all buf_wr_valid bits stay 0, beats still consumed.

Reset
REQ-032 kernel_rst asynchronously forces IDLE, counters 0, latched fields 0, all outputs 0 (busy, ap_done, read_start, data_tready, buf_wr_valid, buf_wr_addr, buf_wr_data, err, request address and size).
REQ-033 Reset mid-STREAM SHALL abandon the transfer with no ap_done; first ap_start after release SHALL be served normally.

Configuration
REQ-034 Macro LOAD_ERR_CHECK_EN defined: err set on tlast with received+1 != count, on count-th beat without tlast, or on buffer id >= NUM_BUF; err is cleared only by reset or an accepted ap_start.
REQ-035 Macro undefined: err tied 0, tlast ignored, all other behaviour identical.

Verification
REQ-036 offset=0, inst id=0, start=0, line offset 2, count=128 -> addr 128, size 8192, 128 writes on channel 0 to addr 0..127, one ap_done.
REQ-037 id=2, start=2040, count=16, tvalid toggled every other cycle -> addrs 2040..2047 then 0..7 on channel 2, only valid beats written.
REQ-038 count=0 -> ap_done 2 cycles after ap_start, no read_start, no writes.
REQ-039 Source supplies 20 beats for count=16 -> exactly 16 writes, tready low from beat 17 onward.
REQ-040 kernel_rst asserted after beat 5 of 64 -> all outputs 0 immediately, no ap_done; next instruction completes correctly.
REQ-041 With LOAD_ERR_CHECK_EN: tlast on beat 10 of 16 -> err=1; id=9 with NUM_BUF=5 -> err=1, no buffer writes.
